// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and width helper for the keypad scanner.
package keypad_pkg;

  localparam int unsigned DefaultNCols    = 4;
  localparam int unsigned DefaultNRows    = 4;
  localparam int unsigned DefaultDebounce = 3;

  // Scanner FSM state encoding
  localparam logic [1:0] StScan      = 2'd0;
  localparam logic [1:0] StPressDb   = 2'd1;
  localparam logic [1:0] StHeld      = 2'd2;
  localparam logic [1:0] StReleaseDb = 2'd3;

  // Key code width for a rows x cols matrix; never narrower than one bit.
  function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
    int unsigned n;
    n = rows * cols;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_keypad_scanner_if.sv
// Keypad scanner signal bundle: tick/row inputs, column strobes and key reporting.
interface matrix_keypad_scanner_if #(
  parameter int unsigned N_COLS = keypad_pkg::DefaultNCols,
  parameter int unsigned N_ROWS = keypad_pkg::DefaultNRows
) ();
  import keypad_pkg::*;

  localparam int unsigned KW = key_width(N_ROWS, N_COLS);

  logic              scan_tick;
  logic [N_ROWS-1:0] row_n;
  logic [N_COLS-1:0] col_n;
  logic [KW-1:0]     key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_err;

  // Scanner side
  modport master (
    input  scan_tick,
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held,
    output multi_err
  );

  // Keypad / controller side
  modport slave (
    output scan_tick,
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  multi_err
  );

endinterface

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones (idle pull-up level).
module input_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Column-strobed key matrix scanner with press/release debounce and single-key reporting.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned N_COLS   = DefaultNCols,
  parameter int unsigned N_ROWS   = DefaultNRows,
  parameter int unsigned DEBOUNCE = DefaultDebounce
) (
  input logic                     clock,
  input logic                     reset,
  matrix_keypad_scanner_if.master kp
);

  localparam int unsigned KW = key_width(N_ROWS, N_COLS);
  localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  logic [N_ROWS-1:0] rs_n;
  logic [N_ROWS-1:0] rows_low;
  logic              one_low;
  logic              any_low;
  logic [RW-1:0]     row_idx;
  logic [CW-1:0]     col_next;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] db_q, db_d;
  logic [CW-1:0] cap_col_q, cap_col_d;
  logic [RW-1:0] cap_row_q, cap_row_d;
  logic [KW-1:0] key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          multi_err_q, multi_err_d;

  function automatic logic [KW-1:0] make_code(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return KW'(row) * KW'(N_COLS) + KW'(col);
  endfunction

  input_sync #(
    .Width (N_ROWS)
  ) u_row_sync (
    .clock (clock),
    .reset (reset),
    .din   (kp.row_n),
    .dout  (rs_n)
  );

  // Row decode: which rows are pulled low and whether exactly one is
  always_comb begin
    rows_low = ~rs_n;
    any_low  = (rows_low != '0);
    one_low  = any_low && ((rows_low & (rows_low - 1'b1)) == '0);
    row_idx  = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (rows_low[r]) row_idx = RW'(r);
    end
    col_next = (col_q == CW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
  end

  // Scan / debounce FSM next state; everything only moves on scan_tick
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    db_d        = db_q;
    cap_col_d   = cap_col_q;
    cap_row_d   = cap_row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_err_d = 1'b0;

    if (kp.scan_tick) begin
      case (state_q)
        StScan: begin
          if (one_low) begin
            cap_col_d = col_q;
            cap_row_d = row_idx;
            if (DEBOUNCE <= 1) begin
              key_code_d  = make_code(row_idx, col_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              db_d        = '0;
              state_d     = StHeld;
            end else begin
              db_d    = DW'(1);
              state_d = StPressDb;
            end
          end else begin
            multi_err_d = any_low;
            col_d       = col_next;
          end
        end
        StPressDb: begin
          if (one_low && (row_idx == cap_row_q)) begin
            if ((db_q + 1'b1) == DW'(DEBOUNCE)) begin
              key_code_d  = make_code(cap_row_q, cap_col_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              db_d        = '0;
              state_d     = StHeld;
            end else begin
              db_d = db_q + 1'b1;
            end
          end else begin
            db_d    = '0;
            col_d   = col_next;
            state_d = StScan;
          end
        end
        StHeld: begin
          // Other rows going low are ignored: no rollover while a key is held
          if (!any_low) begin
            if (DEBOUNCE <= 1) begin
              key_held_d = 1'b0;
              col_d      = col_next;
              db_d       = '0;
              state_d    = StScan;
            end else begin
              db_d    = DW'(1);
              state_d = StReleaseDb;
            end
          end
        end
        StReleaseDb: begin
          if (!any_low) begin
            if ((db_q + 1'b1) == DW'(DEBOUNCE)) begin
              key_held_d = 1'b0;
              col_d      = col_next;
              db_d       = '0;
              state_d    = StScan;
            end else begin
              db_d = db_q + 1'b1;
            end
          end else begin
            db_d    = '0;
            state_d = StHeld;
          end
        end
        default: begin
          db_d    = '0;
          state_d = StScan;
        end
      endcase
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StScan;
      col_q       <= '0;
      db_q        <= '0;
      cap_col_q   <= '0;
      cap_row_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      db_q        <= db_d;
      cap_col_q   <= cap_col_d;
      cap_row_q   <= cap_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  // Active-low one-hot column strobe from the column pointer
  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      kp.col_n[c] = (col_q != CW'(c));
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.multi_err = multi_err_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with a key-matrix model and a key-code scoreboard.
module tb_matrix_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned NR = 4;
  localparam int unsigned DB = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  matrix_keypad_scanner_if #(.N_COLS(NC), .N_ROWS(NR)) kp ();

  matrix_keypad_scanner #(
    .N_COLS   (NC),
    .N_ROWS   (NR),
    .DEBOUNCE (DB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  // Scan tick every 4 clocks
  logic [1:0] tick_cnt = 2'd0;
  always @(posedge clock) tick_cnt <= tick_cnt + 2'd1;
  assign kp.scan_tick = (tick_cnt == 2'd3);

  // Key matrix model: a pressed key pulls its row low while its column is strobed
  logic [NR-1:0][NC-1:0] pressed;
  always_comb begin
    kp.row_n = '1;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (pressed[r][c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
      end
    end
  end

  int         vectors     = 0;
  int         miscompares = 0;
  int         multi_seen  = 0;
  logic [3:0] exp_q[$];

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic int col_idx(input logic [3:0] cn);
    for (int i = 0; i < 4; i++) if (!cn[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    do @(posedge clock); while (kp.scan_tick !== 1'b1);
    @(negedge clock);
  endtask

  // Output monitor: pops expected key codes on key_valid, checks pulse widths
  task automatic monitor();
    logic       valid_prev;
    logic       multi_prev;
    logic [3:0] e;
    valid_prev = 1'b0;
    multi_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (valid_prev) check("valid_one_cycle", 32'(kp.key_valid), 32'd0);
      if (multi_prev) check("multi_one_cycle", 32'(kp.multi_err), 32'd0);
      if (kp.key_valid === 1'b1) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_valid observed code=%0d expected=no pulse", kp.key_code);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("key_code_sb", 32'(kp.key_code), 32'(e));
        end
        check("held_with_valid", 32'(kp.key_held), 32'd1);
      end
      if (kp.multi_err === 1'b1) multi_seen++;
      valid_prev = (kp.key_valid === 1'b1);
      multi_prev = (kp.multi_err === 1'b1);
    end
  endtask

  initial begin
    int c;
    pressed = '0;
    fork
      monitor();
    join_none

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_col_n", 32'(kp.col_n), 32'h0e);
    check("rst_key_code", 32'(kp.key_code), 32'd0);
    check("rst_key_valid", 32'(kp.key_valid), 32'd0);
    check("rst_key_held", 32'(kp.key_held), 32'd0);
    check("rst_multi_err", 32'(kp.multi_err), 32'd0);
    reset = 1'b1;

    // Idle column walk
    for (int k = 1; k <= 8; k++) begin
      next_tick();
      check("idle_walk", 32'(kp.col_n), 32'(col_pat(k % 4)));
    end

    // Single press: row 2, col 1 -> code 9
    pressed[2][1] = 1'b1;
    exp_q.push_back(4'd9);
    repeat (20) next_tick();
    check("press_col_frozen", 32'(kp.col_n), 32'h0d);
    check("press_held", 32'(kp.key_held), 32'd1);
    check("press_code", 32'(kp.key_code), 32'd9);
    check("press_sb_drained", 32'(exp_q.size()), 32'd0);
    pressed[2][1] = 1'b0;
    repeat (2) next_tick();
    check("release_2_held", 32'(kp.key_held), 32'd1);
    next_tick();
    check("release_3_held", 32'(kp.key_held), 32'd0);
    check("release_col_adv", 32'(kp.col_n), 32'h0b);
    check("release_code_kept", 32'(kp.key_code), 32'd9);

    // Bounce: row 0, col 3 toggling every tick, never accepted
    for (int k = 0; k < 12; k++) begin
      pressed[0][3] = 1'b1;
      next_tick();
      pressed[0][3] = 1'b0;
      next_tick();
    end
    check("bounce_held", 32'(kp.key_held), 32'd0);
    c = col_idx(kp.col_n);
    next_tick();
    check("bounce_scan_resumes", 32'(kp.col_n), 32'(col_pat((c + 1) % 4)));

    // Release debounce: row 1, col 3 -> code 7
    pressed[1][3] = 1'b1;
    exp_q.push_back(4'd7);
    for (int k = 0; k < 12 && kp.key_held !== 1'b1; k++) next_tick();
    check("rdb_held", 32'(kp.key_held), 32'd1);
    pressed[1][3] = 1'b0;
    repeat (2) next_tick();
    pressed[1][3] = 1'b1;
    repeat (4) next_tick();
    check("rdb_short_release_held", 32'(kp.key_held), 32'd1);
    check("rdb_col_frozen", 32'(kp.col_n), 32'h07);
    pressed[1][3] = 1'b0;
    repeat (3) next_tick();
    check("rdb_full_release_held", 32'(kp.key_held), 32'd0);
    check("rdb_col_wrap", 32'(kp.col_n), 32'h0e);
    check("rdb_sb_drained", 32'(exp_q.size()), 32'd0);

    // Multi-row: rows 1 and 3 in column 2, two full scans from column 0
    pressed[1][2] = 1'b1;
    pressed[3][2] = 1'b1;
    multi_seen = 0;
    repeat (8) next_tick();
    check("multi_count", 32'(multi_seen), 32'd2);
    check("multi_no_hold", 32'(kp.key_held), 32'd0);
    pressed = '0;

    // Reset mid-debounce: row 0, col 1, reset with db_cnt=2
    pressed[0][1] = 1'b1;
    repeat (3) next_tick();
    check("middb_col_frozen", 32'(kp.col_n), 32'h0d);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_col_n", 32'(kp.col_n), 32'h0e);
    check("midrst_code", 32'(kp.key_code), 32'd0);
    check("midrst_held", 32'(kp.key_held), 32'd0);
    pressed = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) next_tick();
    check("midrst_held_after", 32'(kp.key_held), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
# matrix_keypad_scanner

Scans a multiplexed key matrix and reports debounced single-key presses to the irrigation controller. It drives one active-low column strobe at a time and samples active-low row returns. It then emits a key code with a one-cycle valid pulse, which lets operators enter commands without dedicated switch inputs. It is the input-side counterpart of the LED matrix column/row driver and shares its scan tick source.

## Interface
- N_COLS, 4, number of column strobes driven
- N_ROWS, 4, number of row returns sampled
- DEBOUNCE, 3, consecutive scan ticks a press/release must be stable
- KW, $clog2(N_ROWS*N_COLS), key code width (derived, not overridden)

- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- scan_tick  in  1  one-cycle enable from the clock divider chain; period ≥ 4 clock cycles
- row_n  in  N_ROWS  raw row returns, active-low, externally pulled up, asynchronous
- col_n  out  N_COLS  column strobes, active-low one-hot
- key_code  out  KW  row*N_COLS + col of last accepted key
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high while accepted key remains pressed
- multi_err  out  1  one-cycle pulse when a column shows >1 row low

## Operation
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value rs_n.
- The state machine has four states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: on each scan_tick, evaluate rs_n for the currently driven column, then advance the column (N_COLS-1 wraps to 0).
  - Exactly one row low: capture col/row, hold the column (no advance), set db_cnt=1, go PRESS_DB.
  - More than one row low: pulse multi_err and advance normally.
  - No row low: advance.
- PRESS_DB (column frozen): on each scan_tick, evaluate rs_n.
  - The same single row is low: db_cnt++. When db_cnt reaches DEBOUNCE, load key_code, pulse key_valid, and go HELD.
  - Anything else (release, different row, multiple rows): discard, advance column, go SCAN.
- HELD: key_held=1, column frozen. On a scan_tick with all rows high, set db_cnt=1 and go RELEASE_DB. Other rows going low are ignored (no rollover).
- RELEASE_DB: on each scan_tick:
  - All rows high: db_cnt++. At DEBOUNCE, clear key_held, advance column, go SCAN.
  - Any row low: return to HELD.
- With DEBOUNCE=1, acceptance happens on the first detecting tick and SCAN goes directly to HELD.
- key_code keeps its last accepted value until the next accepted press.

## Timing
- Reset (reset=0 at a rising edge): state SCAN, column 0 driven (col_n = all ones except bit0=0), key_code=0, key_valid=0, key_held=0, multi_err=0, db_cnt=0, synchronizer flops=all ones.
- col_n changes only in the cycle after a scan_tick. The sample taken at a scan_tick therefore reflects the column driven during the whole preceding tick period, which gives a settle time ≥ tick period − 2 cycles.
- key_valid and multi_err are registered. They assert in the cycle after the deciding scan_tick and last exactly one cycle.
- Press latency, for a key held steady from before its column is strobed: detection at the end of that column's window, then DEBOUNCE−1 further ticks, then +1 cycle to key_valid.
- key_held rises with key_valid. It falls one cycle after the DEBOUNCE-th all-high tick in RELEASE_DB.
- scan_tick while reset=0 is ignored.
- A reset mid-debounce or mid-hold aborts with no key_valid.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, PRESS_DB, HELD, RELEASE_DB)
  - KW derivation helper
  - default N_COLS/N_ROWS/DEBOUNCE constants shared with the top level
- One sub-module, input_sync: a parameterized-width 2-flop synchronizer with reset value all ones, instantiated for row_n.
- Column pointer, debounce counter, FSM and output registers all live in matrix_keypad_scanner.

## Test plan
All scenarios use N_COLS=4, N_ROWS=4, DEBOUNCE=3, scan_tick every 4 cycles.
- Reset: hold reset=0 for 3 cycles → col_n=4'b1110, key_code=0, key_valid=0, key_held=0; then 8 idle ticks → col_n walks 1101,1011,0111,1110,…
- Single press: model key (row 2, col 1), held 20 ticks → col_n frozen at 1101, one key_valid pulse with key_code=9, key_held=1 until release.
- Bounce: key (row 0, col 3) low for 1 tick, high 1 tick, repeated → no key_valid; scanning resumes after each break.
- Release debounce: after acceptance, release for 2 ticks then press again → key_held stays 1 and no second key_valid. A full release of 3 ticks → key_held=0 and scanning restarts at col 0 (after 3→0 wrap).
- Multi-row: rows 1 and 3 low in column 2 → multi_err pulse each time column 2 is sampled, no key_valid.
- Reset mid-operation: assert reset in PRESS_DB with db_cnt=2 → next cycle returns to reset values and no key_valid is ever emitted for that press.
